// File: rtl/collatz_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : collatz_datapath
// Description : Datapath for the Collatz sequencer. Holds the working value X
//               and scratch register T and performs load, X+T+1 and halve
//               operations under controller strobes sel/wen/fs1/fs0. Returns
//               the combinational status bits one/x0 and a sticky overflow
//               flag. Optional step counter and peak tracker are built only
//               when the macro COLLATZ_STATS_EN is defined; otherwise steps
//               and peak are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module collatz_datapath #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] start_val,
    input  logic         sel,
    input  logic         wen,
    input  logic         fs1,
    input  logic         fs0,
    output logic         one,
    output logic         x0,
    output logic [W-1:0] x,
    output logic [15:0]  steps,
    output logic [W-1:0] peak,
    output logic         ovf
);

    localparam logic [1:0]  c_FS_ADD    = 2'b01;
    localparam logic [1:0]  c_FS_SHR    = 2'b10;
    localparam logic [15:0] c_STEPS_MAX = 16'hFFFF;

    logic [W-1:0] r_x;
    logic [W-1:0] r_t;
    logic         r_ovf;

    logic [1:0]   w_fs;
    logic [W-1:0] w_d;
    logic [W:0]   w_sum;
    logic [W-1:0] w_x_next;
    logic         w_add;
    logic         w_shr;

    assign w_fs  = {fs1, fs0};
    assign w_add = sel && (w_fs == c_FS_ADD);
    assign w_shr = sel && (w_fs == c_FS_SHR);

    // Operand bus feeds the status bits directly so the seed parity is
    // visible to the controller in the cycle the seed is presented.
    assign w_d = sel ? r_x : start_val;
    assign one = (w_d == {{(W-1){1'b0}}, 1'b1});
    assign x0  = w_d[0];

    // Carry-out of the add lands in w_sum[W] and feeds the overflow flag.
    assign w_sum = {1'b0, r_x} + {1'b0, r_t} + {{W{1'b0}}, 1'b1};

    // Next value of X for the non-reset case; holds when fs is 00 or 11.
    always_comb begin
        w_x_next = r_x;
        if (!sel) begin
            w_x_next = start_val;
        end else if (w_add) begin
            w_x_next = w_sum[W-1:0];
        end else if (w_shr) begin
            w_x_next = {1'b0, r_x[W-1:1]};
        end
    end

    // X, T and sticky overflow; reset still honours wen because the
    // controller issues its first odd-case T load in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x   <= start_val;
            r_t   <= wen ? {start_val[W-2:0], 1'b0} : '0;
            r_ovf <= wen & start_val[W-1];
        end else begin
            r_x <= w_x_next;
            if (wen) begin
                r_t <= {w_d[W-2:0], 1'b0};
            end
            if ((wen && w_d[W-1]) || (w_add && w_sum[W])) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign x   = r_x;
    assign ovf = r_ovf;

`ifdef COLLATZ_STATS_EN
    logic [15:0]  r_steps;
    logic [W-1:0] r_peak;
    logic         w_x_wr;

    // Any cycle that actually rewrites X can raise the peak.
    assign w_x_wr = !sel || w_add || w_shr;

    // Step counter saturates instead of wrapping; peak tracks the max of X.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steps <= '0;
            r_peak  <= start_val;
        end else begin
            if ((w_add || w_shr) && (r_steps != c_STEPS_MAX)) begin
                r_steps <= r_steps + 16'd1;
            end
            if (w_x_wr && (w_x_next > r_peak)) begin
                r_peak <= w_x_next;
            end
        end
    end

    assign steps = r_steps;
    assign peak  = r_peak;
`else
    assign steps = '0;
    assign peak  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_collatz_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_collatz_datapath
// Description : Self-checking bench for collatz_datapath. Acts as the
//               controller, keeps a reference model, pushes expected register
//               state into a scoreboard queue when each cycle is driven and
//               pops/compares after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collatz_datapath;

`ifdef COLLATZ_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] start_val;
    logic        sel;
    logic        wen;
    logic        fs1;
    logic        fs0;
    logic        one;
    logic        x0;
    logic [15:0] x;
    logic [15:0] steps;
    logic [15:0] peak;
    logic        ovf;

    collatz_datapath #(.W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_val (start_val),
        .sel       (sel),
        .wen       (wen),
        .fs1       (fs1),
        .fs0       (fs0),
        .one       (one),
        .x0        (x0),
        .x         (x),
        .steps     (steps),
        .peak      (peak),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] steps;
        logic [15:0] peak;
        logic        ovf;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (steps/peak kept even when stats are disabled)
    logic [15:0] m_x, m_t, m_st, m_pk;
    logic        m_ov;
    logic        m_tl;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one controller cycle, check status bits, score the register update.
    task automatic cyc(input logic r, input logic [15:0] sv, input logic s,
                       input logic we, input logic [1:0] f);
        logic [15:0] d, nx, nt, nst, npk;
        logic [16:0] sum;
        logic        nov, wr;
        exp_t        e, o;
        @(negedge clk);
        reset = r; start_val = sv; sel = s; wen = we; fs1 = f[1]; fs0 = f[0];
        #1;
        d = s ? m_x : sv;
        chk("one", {15'b0, one}, {15'b0, (d == 16'd1)});
        chk("x0", {15'b0, x0}, {15'b0, d[0]});
        if (r) begin
            nx = sv; nt = we ? (sv << 1) : 16'd0; nov = we & sv[15];
            nst = 16'd0; npk = sv;
        end else begin
            sum = {1'b0, m_x} + {1'b0, m_t} + 17'd1;
            nx = m_x; wr = 1'b0;
            if (!s) begin nx = sv; wr = 1'b1; end
            else if (f == 2'b01) begin nx = sum[15:0]; wr = 1'b1; end
            else if (f == 2'b10) begin nx = m_x / 16'd2; wr = 1'b1; end
            nt  = we ? (d * 16'd2) : m_t;
            nov = m_ov | (we & d[15]) | (s & (f == 2'b01) & sum[16]);
            nst = (s && (f == 2'b01 || f == 2'b10) && m_st != 16'hFFFF) ? m_st + 16'd1 : m_st;
            npk = (wr && nx > m_pk) ? nx : m_pk;
        end
        m_x = nx; m_t = nt; m_ov = nov; m_st = nst; m_pk = npk;
        e.x = nx; e.ovf = nov;
        e.steps = c_STATS ? nst : 16'd0;
        e.peak  = c_STATS ? npk : 16'd0;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++; errors++;
            $error("FAIL sb_empty observed 0 expected 1");
        end else begin
            o = q.pop_front();
            chk("x", x, o.x);
            chk("steps", steps, o.steps);
            chk("peak", peak, o.peak);
            chk("ovf", {15'b0, ovf}, {15'b0, o.ovf});
        end
    endtask

    // Run a seed to 1 under model-driven control; optionally stop at a step count.
    task automatic run(input logic [15:0] seed, input int abort_at);
        bit done;
        cyc(1'b1, seed, 1'b0, seed[0], 2'b00);
        m_tl = seed[0];
        chk("rst_x", x, seed);
        chk("rst_steps", steps, 16'd0);
        chk("rst_peak", peak, c_STATS ? seed : 16'd0);
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_x == 16'd1 || (abort_at >= 0 && int'(m_st) == abort_at)) begin
                done = 1'b1;
                break;
            end
            if (!m_x[0]) begin
                cyc(1'b0, 16'($urandom), 1'b1, 1'b0, 2'b10);
            end else begin
                if (!m_tl) cyc(1'b0, 16'($urandom), 1'b1, 1'b1, 2'b00);
                cyc(1'b0, 16'($urandom), 1'b1, 1'b0, 2'b01);
                m_tl = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $error("FAIL run_bound observed %h expected %h", m_x, 16'd1);
        end
    endtask

    initial begin
        reset = 1'b0; start_val = 16'd0; sel = 1'b0; wen = 1'b0; fs1 = 1'b0; fs0 = 1'b0;
        m_x = '0; m_t = '0; m_st = '0; m_pk = '0; m_ov = 1'b0; m_tl = 1'b0;

        // Seed 1: terminal immediately
        run(16'd1, -1);
        chk("s1_x", x, 16'd1);
        chk("s1_one", {15'b0, one}, 16'd1);

        // Seed 6
        run(16'd6, -1);
        chk("s6_x", x, 16'd1);
        chk("s6_steps", steps, c_STATS ? 16'd8 : 16'd0);
        chk("s6_peak", peak, c_STATS ? 16'd16 : 16'd0);
        chk("s6_ovf", {15'b0, ovf}, 16'd0);

        // Seed 7
        run(16'd7, -1);
        chk("s7_steps", steps, c_STATS ? 16'd16 : 16'd0);
        chk("s7_peak", peak, c_STATS ? 16'd52 : 16'd0);
        chk("s7_ovf", {15'b0, ovf}, 16'd0);

        // Seed AAAB: T load overflows in the reset cycle, add wraps
        run(16'hAAAB, -1);
        chk("sA_ovf", {15'b0, ovf}, 16'd1);
        chk("sA_x", x, 16'd1);
        chk("sA_peak", peak, c_STATS ? 16'hAAAB : 16'd0);

        // Seed 0: status bits low, halving keeps zero, no special action
        cyc(1'b1, 16'd0, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 16'h1234, 1'b1, 1'b0, 2'b10);
        cyc(1'b0, 16'h0001, 1'b1, 1'b0, 2'b10);
        chk("s0_x0", {15'b0, x0}, 16'd0);
        chk("s0_ovf", {15'b0, ovf}, 16'd0);

        // Seed 27 interrupted at 10 steps, reseeded with 5
        run(16'd27, 10);
        chk("s27_steps", steps, c_STATS ? 16'd10 : 16'd0);
        run(16'd5, -1);
        chk("s5_steps", steps, c_STATS ? 16'd5 : 16'd0);
        chk("s5_peak", peak, c_STATS ? 16'd16 : 16'd0);
        chk("s5_x", x, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
